miriscv_ram_arbiter: RTL and testbench



---
 rtl/miriscv_ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_miriscv_ram_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_ram_arbiter.sv
// Shares the single-port program/data RAM between instruction fetch, load/store and the
// program loader. It also owns the RUN/LOAD mode and the one-deep read-return tracking.
module miriscv_ram_arbiter #(
   parameter int RAM_SIZE = 512,
   parameter int ADDR_W   = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        ldr_start_i,
   input  logic                        ldr_done_i,
   output logic                        core_halt_o,
   input  logic                        im_req_i,
   input  logic                        im_we_i,
   input  logic [ADDR_W-1:0]           im_addr_i,
   output logic                        im_gnt_o,
   output logic                        im_rvalid_o,
   output logic [31:0]                 im_rdata_o,
   input  logic                        dm_req_i,
   input  logic                        dm_we_i,
   input  logic [ADDR_W-1:0]           dm_addr_i,
   input  logic [3:0]                  dm_be_i,
   input  logic [31:0]                 dm_wdata_i,
   output logic                        dm_gnt_o,
   output logic                        dm_rvalid_o,
   output logic [31:0]                 dm_rdata_o,
   input  logic                        ld_req_i,
   input  logic                        ld_we_i,
   input  logic [ADDR_W-1:0]           ld_addr_i,
   input  logic [3:0]                  ld_be_i,
   input  logic [31:0]                 ld_wdata_i,
   output logic                        ld_gnt_o,
   output logic                        ld_rvalid_o,
   output logic [31:0]                 ld_rdata_o,
   output logic                        ram_req_o,
   output logic                        ram_we_o,
   output logic [3:0]                  ram_be_o,
   output logic [$clog2(RAM_SIZE)-1:0] ram_addr_o,
   output logic [31:0]                 ram_wdata_o,
   input  logic [31:0]                 ram_rdata_i
);

   localparam int                RAW   = $clog2(RAM_SIZE);
   localparam logic [ADDR_W-3:0] WORDS = (ADDR_W-2)'(RAM_SIZE);

   typedef enum logic {ST_RUN, ST_LOAD} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IM, OWN_DM, OWN_LD} owner_t;

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   logic        oor_q, oor_d;
   logic        last_dm_q, last_dm_d;
   logic        im_oor, dm_oor, ld_oor;
   logic [31:0] rdata_ret;
   logic        unused_ok;

   assign im_oor = im_addr_i[ADDR_W-1:2] >= WORDS;
   assign dm_oor = dm_addr_i[ADDR_W-1:2] >= WORDS;
   assign ld_oor = ld_addr_i[ADDR_W-1:2] >= WORDS;

   // Fetch never writes and byte offsets play no part in word addressing.
   assign unused_ok = ^{im_we_i, im_addr_i[1:0], dm_addr_i[1:0], ld_addr_i[1:0]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_RUN;
         owner_q   <= OWN_NONE;
         oor_q     <= 1'b0;
         last_dm_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         oor_q     <= oor_d;
         last_dm_q <= last_dm_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = OWN_NONE;
      oor_d       = 1'b0;
      last_dm_d   = last_dm_q;
      im_gnt_o    = 1'b0;
      dm_gnt_o    = 1'b0;
      ld_gnt_o    = 1'b0;
      ram_req_o   = 1'b0;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;

      case (state_q)
         ST_RUN: begin
            if (ldr_start_i && !ldr_done_i) state_d = ST_LOAD;
            // On a tie the port that lost last time wins.
            if (im_req_i && (!dm_req_i || last_dm_q)) im_gnt_o = 1'b1;
            else if (dm_req_i)                         dm_gnt_o = 1'b1;
         end
         ST_LOAD: begin
            if (ldr_done_i && !ldr_start_i) state_d = ST_RUN;
            ld_gnt_o = ld_req_i;
         end
         default: state_d = ST_RUN;
      endcase

      if (im_gnt_o) begin
         owner_d    = OWN_IM;
         oor_d      = im_oor;
         last_dm_d  = 1'b0;
         ram_req_o  = !im_oor;
         ram_addr_o = im_addr_i[2 +: RAW];
      end else if (dm_gnt_o) begin
         owner_d     = OWN_DM;
         oor_d       = dm_oor;
         last_dm_d   = 1'b1;
         ram_req_o   = !dm_oor;
         ram_we_o    = dm_we_i && !dm_oor;
         ram_be_o    = dm_be_i;
         ram_addr_o  = dm_addr_i[2 +: RAW];
         ram_wdata_o = dm_wdata_i;
      end else if (ld_gnt_o) begin
         owner_d     = OWN_LD;
         oor_d       = ld_oor;
         ram_req_o   = !ld_oor;
         ram_we_o    = ld_we_i && !ld_oor;
         ram_be_o    = ld_be_i;
         ram_addr_o  = ld_addr_i[2 +: RAW];
         ram_wdata_o = ld_wdata_i;
      end
   end

   assign core_halt_o = (state_q == ST_LOAD);

   // Out-of-range accesses never reached the RAM, so they answer with zero.
   assign rdata_ret   = oor_q ? 32'd0 : ram_rdata_i;

   assign im_rvalid_o = (owner_q == OWN_IM);
   assign dm_rvalid_o = (owner_q == OWN_DM);
   assign ld_rvalid_o = (owner_q == OWN_LD);
   assign im_rdata_o  = im_rvalid_o ? rdata_ret : 32'd0;
   assign dm_rdata_o  = dm_rvalid_o ? rdata_ret : 32'd0;
   assign ld_rdata_o  = ld_rvalid_o ? rdata_ret : 32'd0;

endmodule

// File: tb/tb_miriscv_ram_arbiter.sv
// Bench for miriscv_ram_arbiter: a behavioural RAM behind the arbiter, a golden memory
// image and a queue of expected responses checked one cycle after each grant.
module tb_miriscv_ram_arbiter;

   localparam int RAM_SIZE = 512;
   localparam int ADDR_W   = 32;
   localparam int RAW      = $clog2(RAM_SIZE);

   logic              clk_i, rst_i, ldr_start_i, ldr_done_i, core_halt_o;
   logic              im_req_i, im_we_i, im_gnt_o, im_rvalid_o;
   logic [ADDR_W-1:0] im_addr_i;
   logic [31:0]       im_rdata_o;
   logic              dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
   logic [ADDR_W-1:0] dm_addr_i;
   logic [3:0]        dm_be_i;
   logic [31:0]       dm_wdata_i, dm_rdata_o;
   logic              ld_req_i, ld_we_i, ld_gnt_o, ld_rvalid_o;
   logic [ADDR_W-1:0] ld_addr_i;
   logic [3:0]        ld_be_i;
   logic [31:0]       ld_wdata_i, ld_rdata_o;
   logic              ram_req_o, ram_we_o;
   logic [3:0]        ram_be_o;
   logic [RAW-1:0]    ram_addr_o;
   logic [31:0]       ram_wdata_o, ram_rdata_i;

   miriscv_ram_arbiter #(.RAM_SIZE(RAM_SIZE), .ADDR_W(ADDR_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ldr_start_i(ldr_start_i), .ldr_done_i(ldr_done_i),
      .core_halt_o(core_halt_o),
      .im_req_i(im_req_i), .im_we_i(im_we_i), .im_addr_i(im_addr_i), .im_gnt_o(im_gnt_o),
      .im_rvalid_o(im_rvalid_o), .im_rdata_o(im_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_be_i(dm_be_i),
      .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
      .dm_rdata_o(dm_rdata_o),
      .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_be_i(ld_be_i),
      .ld_wdata_i(ld_wdata_i), .ld_gnt_o(ld_gnt_o), .ld_rvalid_o(ld_rvalid_o),
      .ld_rdata_o(ld_rdata_o),
      .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
      .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Behavioural single-port RAM with one-cycle read latency; reset reloads the preset words.
   logic [31:0] mem [0:RAM_SIZE-1];
   always @(posedge clk_i) begin
      if (rst_i) begin
         mem[0] <= 32'h0040_0113;
         mem[8] <= 32'h1234_5678;
      end
      if (ram_req_o) begin
         if (ram_we_o) begin
            for (int b = 0; b < 4; b++)
               if (ram_be_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
         end
         ram_rdata_i <= mem[ram_addr_o];
      end
   end

   typedef struct {
      logic [2:0]  vld;
      logic        chk;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [0:RAM_SIZE-1];
   int          n_checks = 0;
   int          n_fail   = 0;

   localparam logic [2:0] G_NONE = 3'b000, G_IM = 3'b001, G_DM = 3'b010, G_LD = 3'b100;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic idle();
      rst_i = 1'b0; ldr_start_i = 1'b0; ldr_done_i = 1'b0;
      im_req_i = 1'b0; im_we_i = 1'b0; im_addr_i = '0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_be_i = '0; dm_wdata_i = '0;
      ld_req_i = 1'b0; ld_we_i = 1'b0; ld_addr_i = '0; ld_be_i = '0; ld_wdata_i = '0;
   endtask

   // Inputs are already driven; check last cycle's response and this cycle's grant.
   task automatic step(input logic [2:0] exp_gnt, input logic exp_halt, input string tag);
      exp_t        e, n;
      logic [31:0] a, wd;
      logic        w, oor, exp_req;
      logic [3:0]  be;
      int          idx;
      @(negedge clk_i);
      if (sb.size() == 0) begin
         check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_eq({tag, ".rvalid"}, {29'd0, ld_rvalid_o, dm_rvalid_o, im_rvalid_o}, {29'd0, e.vld});
         if (!(e.vld[0] && !e.chk)) check_eq({tag, ".im_rdata"}, im_rdata_o, e.vld[0] ? e.data : 32'd0);
         if (!(e.vld[1] && !e.chk)) check_eq({tag, ".dm_rdata"}, dm_rdata_o, e.vld[1] ? e.data : 32'd0);
         if (!(e.vld[2] && !e.chk)) check_eq({tag, ".ld_rdata"}, ld_rdata_o, e.vld[2] ? e.data : 32'd0);
      end
      check_eq({tag, ".gnt"}, {29'd0, ld_gnt_o, dm_gnt_o, im_gnt_o}, {29'd0, exp_gnt});
      check_eq({tag, ".halt"}, {31'd0, core_halt_o}, {31'd0, exp_halt});

      a = '0; w = 1'b0; be = '0; wd = '0;
      case (exp_gnt)
         G_IM: a = im_addr_i;
         G_DM: begin a = dm_addr_i; w = dm_we_i; be = dm_be_i; wd = dm_wdata_i; end
         G_LD: begin a = ld_addr_i; w = ld_we_i; be = ld_be_i; wd = ld_wdata_i; end
         default: ;
      endcase
      oor     = (a >> 2) >= RAM_SIZE;
      idx     = int'(a >> 2);
      exp_req = (exp_gnt != G_NONE) && !oor;
      check_eq({tag, ".ram_req"}, {31'd0, ram_req_o}, {31'd0, exp_req});
      if (exp_req) begin
         check_eq({tag, ".ram_addr"}, {23'd0, ram_addr_o}, {23'd0, a[2 +: RAW]});
         check_eq({tag, ".ram_we"}, {31'd0, ram_we_o}, {31'd0, w});
      end

      n.vld  = rst_i ? G_NONE : exp_gnt;
      n.chk  = !w || oor;
      n.data = 32'd0;
      if (exp_req) begin
         if (w) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
         end else begin
            n.data = ref_mem[idx];
         end
      end
      sb.push_back(n);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      exp_t none;
      none.vld = G_NONE; none.chk = 1'b1; none.data = 32'd0;
      for (int i = 0; i < RAM_SIZE; i++) ref_mem[i] = 32'd0;
      ref_mem[0] = 32'h0040_0113;
      ref_mem[8] = 32'h1234_5678;

      idle();
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      sb.push_back(none);
      step(G_NONE, 1'b0, "reset");
      idle();
      step(G_NONE, 1'b0, "idle");

      im_req_i = 1'b1; im_addr_i = 32'h0;
      step(G_IM, 1'b0, "im_rd0");
      idle();
      step(G_NONE, 1'b0, "im_rd0_ret");

      im_req_i = 1'b1; im_addr_i = 32'h0;
      dm_req_i = 1'b1; dm_addr_i = 32'h20;
      for (int i = 0; i < 6; i++)
         step(i % 2 == 0 ? G_DM : G_IM, 1'b0, $sformatf("rr%0d", i));

      idle();
      ldr_start_i = 1'b1; im_req_i = 1'b1; im_addr_i = 32'h0;
      step(G_IM, 1'b0, "start_with_im");
      ldr_start_i = 1'b0;
      ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 32'h10; ld_be_i = 4'hF; ld_wdata_i = 32'hDEAD_BEEF;
      step(G_LD, 1'b1, "ld_wr");
      ld_req_i = 1'b0; ld_we_i = 1'b0;
      step(G_NONE, 1'b1, "load_im_blocked");
      ldr_done_i = 1'b1;
      step(G_NONE, 1'b1, "done_cycle");
      ldr_done_i = 1'b0; im_addr_i = 32'h10;
      step(G_IM, 1'b0, "im_rd_loaded");

      idle();
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h20; dm_be_i = 4'h3; dm_wdata_i = 32'h0000_AAAA;
      step(G_DM, 1'b0, "dm_wr_be3");
      dm_we_i = 1'b0; dm_be_i = 4'hF; dm_wdata_i = '0;
      step(G_DM, 1'b0, "dm_rd_merged");
      dm_addr_i = 32'(4 * RAM_SIZE);
      step(G_DM, 1'b0, "dm_rd_oor");
      idle();
      step(G_NONE, 1'b0, "oor_ret");

      rst_i = 1'b1; im_req_i = 1'b1; im_addr_i = 32'h0;
      step(G_IM, 1'b0, "im_gnt_under_rst");
      rst_i = 1'b0; dm_req_i = 1'b1; dm_addr_i = 32'h0;
      step(G_DM, 1'b0, "tie_after_rst");
      idle();
      step(G_NONE, 1'b0, "drain0");
      step(G_NONE, 1'b0, "drain1");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
